// File: rtl/switch_button_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_button_input_pkg
//  Description : Shared definitions for the switch/button input peripheral:
//                bus widths, register word offsets (byte address >> 2),
//                CTRL field positions and the register decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_button_input_pkg;

    localparam int BUS_W        = 32;
    localparam int BYTE_EN_W    = 4;
    localparam int WORD_ADDR_W  = 30;

    // Word offsets of the mapped registers (byte addresses 0x7f60..0x7f6c)
    localparam logic [WORD_ADDR_W-1:0] WORD_SW_LO = 30'h0000_1fd8;
    localparam logic [WORD_ADDR_W-1:0] WORD_SW_HI = 30'h0000_1fd9;
    localparam logic [WORD_ADDR_W-1:0] WORD_BTN   = 30'h0000_1fda;
    localparam logic [WORD_ADDR_W-1:0] WORD_CTRL  = 30'h0000_1fdb;

    // CTRL layout: EDGE flags in the low byte, interrupt enables above them
    localparam int CTRL_FIELD_W  = 8;
    localparam int CTRL_EDGE_LSB = 0;
    localparam int CTRL_IE_LSB   = 8;

    typedef enum logic [2:0] {
        REG_NONE  = 3'd0,
        REG_SW_LO = 3'd1,
        REG_SW_HI = 3'd2,
        REG_BTN   = 3'd3,
        REG_CTRL  = 3'd4
    } reg_sel_e;

    function automatic reg_sel_e decode_word(input logic [WORD_ADDR_W-1:0] word);
        reg_sel_e sel;
        case (word)
            WORD_SW_LO: sel = REG_SW_LO;
            WORD_SW_HI: sel = REG_SW_HI;
            WORD_BTN:   sel = REG_BTN;
            WORD_CTRL:  sel = REG_CTRL;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage : switch_button_input_pkg
`default_nettype wire

// File: rtl/switch_button_input_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_button_input_if
//  Description : CPU bridge bus as seen by the input peripheral.
//                Addr   - byte address
//                ByteEn - byte write enables, any bit set marks a write
//                Din    - write data
//                Dout   - combinational read data
//                irq    - level interrupt request, active-high
//                master = bridge side, slave = peripheral side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_button_input_if;
    import switch_button_input_pkg::*;

    logic [BUS_W-1:0]     Addr;
    logic [BYTE_EN_W-1:0] ByteEn;
    logic [BUS_W-1:0]     Din;
    logic [BUS_W-1:0]     Dout;
    logic                 irq;

    modport master (
        output Addr,
        output ByteEn,
        output Din,
        input  Dout,
        input  irq
    );

    modport slave (
        input  Addr,
        input  ByteEn,
        input  Din,
        output Dout,
        output irq
    );

endinterface : switch_button_input_if
`default_nettype wire

// File: rtl/switch_button_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_button_input_debouncer
//  Description : Input debouncer for a vector of raw asynchronous pins.
//                Two-flop synchroniser, optional inversion, then a per-bit
//                sample window evaluated on each tick. A level only changes
//                when STABLE_SAMPLES consecutive tick samples agree.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                tick_i     - one-cycle sample strobe
//                raw_i      - raw pins (asynchronous)
//                level_o    - debounced levels, 1 = pressed/on
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_button_input_debouncer #(
    parameter int WIDTH          = 8,
    parameter int STABLE_SAMPLES = 3,
    parameter int ACTIVE_LOW     = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             tick_i,
    input  wire logic [WIDTH-1:0] raw_i,
    output logic      [WIDTH-1:0] level_o
);

    // Older samples kept besides the incoming one; together they form the
    // STABLE_SAMPLES-deep window.
    localparam int HIST_D = STABLE_SAMPLES - 1;

    // Synchroniser flops come out of reset at the idle pin level so that no
    // phantom "pressed" value is seen while they refill.
    localparam logic [WIDTH-1:0] IDLE_RAW = {WIDTH{ACTIVE_LOW != 0}};

    logic [WIDTH-1:0]             sync1_q;
    logic [WIDTH-1:0]             sync2_q;
    logic [WIDTH-1:0]             w_synced;
    logic [HIST_D-1:0][WIDTH-1:0] hist_q;
    logic [HIST_D-1:0][WIDTH-1:0] hist_d;
    logic [WIDTH-1:0]             level_q;
    logic [WIDTH-1:0]             level_d;
    logic [WIDTH-1:0]             w_all_one;
    logic [WIDTH-1:0]             w_all_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    if (ACTIVE_LOW != 0) begin : g_invert
        assign w_synced = ~sync2_q;
    end else begin : g_direct
        assign w_synced = sync2_q;
    end

    always_comb begin
        w_all_one  = w_synced;
        w_all_zero = ~w_synced;
        for (int k = 0; k < HIST_D; k++) begin
            w_all_one  = w_all_one  & hist_q[k];
            w_all_zero = w_all_zero & ~hist_q[k];
        end
    end

    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick_i) begin
            hist_d[0] = w_synced;
            for (int k = 1; k < HIST_D; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            // Unanimous window forces the level; disagreement holds it
            level_d = (level_q & ~w_all_zero) | w_all_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            level_q <= '0;
        end else begin
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule : switch_button_input_debouncer
`default_nettype wire

// File: rtl/switch_button_input.sv
`default_nettype none
// ============================================================================
//  Module      : switch_button_input
//  Description : Memory-mapped input peripheral. Debounces 64 DIP switches
//                and 8 push buttons, exposes the levels to the CPU bridge,
//                latches button press edges into W1C flags and raises a
//                maskable level interrupt.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                sw_i     - raw DIP switch pins (asynchronous)
//                btn_i    - raw push-button pins (asynchronous)
//                bus      - CPU bridge bus (slave modport)
//  Registers   : 0x7f60 SW_LO, 0x7f64 SW_HI, 0x7f68 BTN (read-only)
//                0x7f6c CTRL {16'b0, IE[7:0], EDGE[7:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_button_input
    import switch_button_input_pkg::*;
#(
    parameter int SAMPLE_PERIOD  = 25000,
    parameter int STABLE_SAMPLES = 3,
    parameter int ACTIVE_LOW     = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [63:0] sw_i,
    input  wire logic [7:0]  btn_i,
    switch_button_input_if.slave bus
);

    localparam int                CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    w_tick;
    logic [63:0]             w_sw_db;
    logic [7:0]              w_btn_db;
    logic [CTRL_FIELD_W-1:0] prev_btn_q;
    logic [CTRL_FIELD_W-1:0] edge_q;
    logic [CTRL_FIELD_W-1:0] edge_d;
    logic [CTRL_FIELD_W-1:0] ie_q;
    logic [CTRL_FIELD_W-1:0] ie_d;
    logic [CTRL_FIELD_W-1:0] w_clr;
    reg_sel_e                w_sel;
    logic                    w_ctrl_wr;
    logic                    w_unused;

    // ------------------------------------------------------------------
    // Shared sample-tick generator
    // ------------------------------------------------------------------
    assign w_tick = (cnt_q == CNT_LAST);
    assign cnt_d  = w_tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    switch_button_input_debouncer #(
        .WIDTH          (64),
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_sw_debounce (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (w_tick),
        .raw_i   (sw_i),
        .level_o (w_sw_db)
    );

    switch_button_input_debouncer #(
        .WIDTH          (8),
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (w_tick),
        .raw_i   (btn_i),
        .level_o (w_btn_db)
    );

    // ------------------------------------------------------------------
    // Register decode and CTRL update
    // ------------------------------------------------------------------
    assign w_sel     = decode_word(bus.Addr[BUS_W-1:2]);
    assign w_ctrl_wr = (|bus.ByteEn) && (w_sel == REG_CTRL);
    assign w_clr     = (w_ctrl_wr && bus.ByteEn[0]) ?
                       bus.Din[CTRL_EDGE_LSB +: CTRL_FIELD_W] : '0;

    // Rising-edge set is ORed after the clear so a simultaneous W1C loses
    assign edge_d = (edge_q & ~w_clr) | (w_btn_db & ~prev_btn_q);
    assign ie_d   = (w_ctrl_wr && bus.ByteEn[1]) ?
                    bus.Din[CTRL_IE_LSB +: CTRL_FIELD_W] : ie_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_btn_q <= '0;
            edge_q     <= '0;
            ie_q       <= '0;
        end else begin
            prev_btn_q <= w_btn_db;
            edge_q     <= edge_d;
            ie_q       <= ie_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt (both purely from registers/address)
    // ------------------------------------------------------------------
    always_comb begin
        bus.Dout = '0;
        case (w_sel)
            REG_SW_LO: bus.Dout = w_sw_db[31:0];
            REG_SW_HI: bus.Dout = w_sw_db[63:32];
            REG_BTN:   bus.Dout = {24'b0, w_btn_db};
            REG_CTRL: begin
                bus.Dout[CTRL_EDGE_LSB +: CTRL_FIELD_W] = edge_q;
                bus.Dout[CTRL_IE_LSB   +: CTRL_FIELD_W] = ie_q;
            end
            default: bus.Dout = '0;
        endcase
    end

    assign bus.irq = |(edge_q & ie_q);

    // Byte-offset address bits and upper write-data bits carry no meaning
    assign w_unused = ^{bus.Addr[1:0], bus.Din};

endmodule : switch_button_input
`default_nettype wire

// File: tb/tb_switch_button_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_button_input
//  Description : Self-checking bench for switch_button_input with a
//                behavioural run-length debounce model, a per-cycle compare
//                process and directed/random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_button_input;

    localparam int P = 4;   // sample period
    localparam int S = 3;   // stable samples

    localparam logic [31:0] A_SW_LO = 32'h0000_7f60;
    localparam logic [31:0] A_SW_HI = 32'h0000_7f64;
    localparam logic [31:0] A_BTN   = 32'h0000_7f68;
    localparam logic [31:0] A_CTRL  = 32'h0000_7f6c;
    localparam logic [31:0] A_NONE  = 32'h0000_7f70;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] sw;
    logic [7:0]  btn;

    switch_button_input_if bus();

    switch_button_input #(
        .SAMPLE_PERIOD  (P),
        .STABLE_SAMPLES (S),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_i  (sw),
        .btn_i (btn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: pins reach the sampler two cycles late, a sample
    // is taken every P cycles, and a level follows a value once it has been
    // seen on S samples in a row (run-length formulation).
    // ------------------------------------------------------------------
    logic [71:0] m_p1, m_p2, m_deb;
    logic [7:0]  m_prev, m_edge, m_ie;
    int          m_cnt;
    int          m_run [72];
    bit          m_last[72];
    bit          m_valid = 1'b0;

    task automatic model_step();
        logic [71:0] synced;
        logic [7:0]  rise, clr;
        bit          tick;
        if (rst) begin
            m_p1 = '1; m_p2 = '1; m_deb = '0;
            m_prev = '0; m_edge = '0; m_ie = '0; m_cnt = 0;
            for (int i = 0; i < 72; i++) begin m_run[i] = S; m_last[i] = 1'b0; end
            m_valid = 1'b1;
        end else begin
            synced = ~m_p2;
            tick   = (m_cnt == P - 1);
            rise   = m_deb[71:64] & ~m_prev;
            clr    = '0;
            if (bus.Addr[31:2] == A_CTRL[31:2]) begin
                if (bus.ByteEn[0]) clr  = bus.Din[7:0];
                if (bus.ByteEn[1]) m_ie = bus.Din[15:8];
            end
            m_edge = (m_edge & ~clr) | rise;
            m_prev = m_deb[71:64];
            if (tick) begin
                for (int i = 0; i < 72; i++) begin
                    if (synced[i] == m_last[i]) m_run[i] = (m_run[i] < S) ? m_run[i] + 1 : S;
                    else begin m_run[i] = 1; m_last[i] = synced[i]; end
                    if (m_run[i] >= S) m_deb[i] = m_last[i];
                end
            end
            m_cnt = tick ? 0 : m_cnt + 1;
            m_p2  = m_p1;
            m_p1  = {btn, sw};
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if      (a[31:2] == A_SW_LO[31:2]) r = m_deb[31:0];
        else if (a[31:2] == A_SW_HI[31:2]) r = m_deb[63:32];
        else if (a[31:2] == A_BTN[31:2])   r = {24'b0, m_deb[71:64]};
        else if (a[31:2] == A_CTRL[31:2])  r = {16'b0, m_ie, m_edge};
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_dout", bus.Dout, m_read(bus.Addr));
            check("model_irq", {31'b0, bus.irq}, {31'b0, |(m_edge & m_ie)});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the active edge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.Addr = a;
        @(negedge clk);
        check(name, bus.Dout, exp);
        @(posedge clk);
        #2;
    endtask

    task automatic rd_irq(input logic [31:0] a, input logic [31:0] exp, input logic exp_irq, input string name);
        bus.Addr = a;
        @(negedge clk);
        check(name, bus.Dout, exp);
        check({name, "_irq"}, {31'b0, bus.irq}, {31'b0, exp_irq});
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.Addr   = a;
        bus.Din    = d;
        bus.ByteEn = be;
        @(posedge clk);
        #2;
        bus.ByteEn = 4'b0;
    endtask

    // Ends on the negedge at which BTN bit is first seen set
    task automatic wait_btn(input int bitn, output bit ok);
        ok = 1'b0;
        bus.Addr = A_BTN;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (bus.Dout[bitn]) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int found;
        int idx;
        rst = 1'b1; sw = '1; btn = '1;
        bus.Addr = '0; bus.ByteEn = '0; bus.Din = '0;
        step(4);
        rst = 1'b0;

        // Reset state, pins idle
        rd_irq(A_SW_LO, 32'h0, 1'b0, "reset_sw_lo");
        rd(A_SW_HI, 32'h0, "reset_sw_hi");
        rd(A_BTN,   32'h0, "reset_btn");
        rd(A_CTRL,  32'h0, "reset_ctrl");
        step(20);
        rd(A_SW_LO, 32'h0, "idle_sw_lo");
        rd(A_SW_HI, 32'h0, "idle_sw_hi");
        rd_irq(A_BTN, 32'h0, 1'b0, "idle_btn");

        // Switch latency
        step($urandom_range(0, 3));
        sw[0] = 1'b0; sw[63] = 1'b0;
        bus.Addr = A_SW_LO;
        found = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (found < 0 && bus.Dout == 32'h1) found = n - 1;
        end
        checks++;
        if (found >= 10 && found <= 14) passes++;
        else $display("FAIL sw_latency: changed after %0d cycles, expected 10..14", found);
        step(1);
        rd(A_SW_LO, 32'h0000_0001, "sw_lo_on");
        rd(A_SW_HI, 32'h8000_0000, "sw_hi_on");

        // Bouncing button must never debounce
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) btn[2] = ~btn[2];
            bus.Addr = A_BTN;
            @(negedge clk);
            check("bounce_btn", bus.Dout, 32'h0);
            step(1);
        end
        btn[2] = 1'b1;
        step(20);
        rd(A_BTN,  32'h0, "bounce_btn_after");
        rd(A_CTRL, 32'h0, "bounce_ctrl_after");

        // Enable IE[2], press btn[2]
        wr(A_CTRL, 32'h0000_0400, 4'b0010);
        rd(A_CTRL, 32'h0000_0400, "ie_written");
        btn[2] = 1'b0;
        wait_btn(2, ok);
        check("btn2_seen", {31'b0, ok}, 32'h1);
        check("btn2_level", bus.Dout, 32'h4);
        check("irq_before_edge", {31'b0, bus.irq}, 32'h0);
        step(1);
        rd_irq(A_CTRL, 32'h0000_0404, 1'b1, "edge2_set");

        // W1C while held, then release and re-press
        wr(A_CTRL, 32'h0000_0004, 4'b0001);
        rd_irq(A_CTRL, 32'h0000_0400, 1'b0, "edge2_cleared");
        step(10);
        rd(A_CTRL, 32'h0000_0400, "edge2_held_stays_clear");
        btn[2] = 1'b1;
        step(20);
        rd(A_BTN,  32'h0, "btn2_released");
        rd(A_CTRL, 32'h0000_0400, "release_no_edge");
        btn[2] = 1'b0;
        step(20);
        rd_irq(A_CTRL, 32'h0000_0404, 1'b1, "edge2_repress");

        // W1C colliding with the set of EDGE[3]
        btn[3] = 1'b0;
        wait_btn(3, ok);
        check("btn3_seen", {31'b0, ok}, 32'h1);
        #1;
        bus.Addr = A_CTRL; bus.Din = 32'h0000_0008; bus.ByteEn = 4'b0001;
        @(posedge clk);
        #2;
        bus.ByteEn = 4'b0;
        rd(A_CTRL, 32'h0000_040c, "edge3_set_wins");
        wr(A_CTRL, 32'h0000_0008, 4'b0001);
        rd(A_CTRL, 32'h0000_0404, "edge3_cleared");
        wr(A_CTRL, 32'hffff_ffff, 4'b0000);
        rd(A_CTRL, 32'h0000_0404, "byteen_zero_no_write");
        wr(A_CTRL, 32'hffff_ffff, 4'b1100);
        rd(A_CTRL, 32'h0000_0404, "upper_bytes_ignored");
        rd(A_NONE, 32'h0, "unmapped_read");
        wr(A_NONE, 32'hffff_ffff, 4'b1111);
        rd(A_CTRL, 32'h0000_0404, "unmapped_write_ignored");

        // Randomised traffic, checked every cycle by the model compare
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, 63);
                sw[idx] = ~sw[idx];
            end
            if ($urandom_range(0, 11) == 0) begin
                idx = $urandom_range(0, 7);
                btn[idx] = ~btn[idx];
            end
            case ($urandom_range(0, 5))
                0: bus.Addr = A_SW_LO;
                1: bus.Addr = A_SW_HI;
                2: bus.Addr = A_BTN;
                3: bus.Addr = A_CTRL;
                4: bus.Addr = A_NONE;
                default: bus.Addr = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                bus.Addr   = A_CTRL;
                bus.Din    = $urandom;
                bus.ByteEn = 4'($urandom_range(0, 15));
            end else begin
                bus.ByteEn = 4'b0;
            end
            step(1);
        end
        bus.ByteEn = 4'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_switch_button_input
`default_nettype wire

// File: doc/switch_button_input.md
Name: switch_button_input

Overview:
- Memory-mapped input peripheral; the read-side counterpart to the display controller.
- Samples the 64 DIP switches and 8 push buttons, synchronises and debounces them, and exposes the debounced levels to the CPU bridge.
- Latches button press edges into sticky flags that software clears with write-1-to-clear (W1C).
- Raises a maskable interrupt request.

Parameters:
- SAMPLE_PERIOD, 25000: clock cycles between debounce sample ticks.
- STABLE_SAMPLES, 3: consecutive agreeing samples required before a debounced bit changes (range 2..8).
- ACTIVE_LOW, 1: when 1, raw pins are inverted after synchronisation, so a pressed/on input reads as 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sw  input  64  raw DIP switch pins, asynchronous
- btn  input  8  raw push-button pins, asynchronous
- Addr  input  32  bus byte address
- ByteEn  input  4  byte write enables; any bit set = write cycle
- Din  input  32  bus write data
- Dout  output  32  combinational read data
- irq  output  1  interrupt request, level, active-high

Behaviour:
- Register map (decode on Addr>>2; unmapped words read 0 and ignore writes):
  - 0x7f60 SW_LO: debounced sw[31:0]. Read-only.
  - 0x7f64 SW_HI: debounced sw[63:32]. Read-only.
  - 0x7f68 BTN: {24'b0, debounced btn[7:0]}. Read-only.
  - 0x7f6c CTRL: {16'b0, IE[7:0], EDGE[7:0]}.
    - ByteEn[0] write: EDGE <= EDGE & ~Din[7:0] (W1C).
    - ByteEn[1] write: IE <= Din[15:8].
    - Other ByteEn bits are ignored.
- Reset values: all debounced levels 0, EDGE 0, IE 0, sample counter 0, sample history 0, Dout per map (0 at reset), irq 0.
- Input path: two-flop synchroniser per raw bit, then optional inversion. Synchronised value is valid 2 cycles after a pin change.
- Sample counter:
  - Counts 0..SAMPLE_PERIOD-1.
  - tick asserts for one cycle when counter == SAMPLE_PERIOD-1; the counter wraps to 0 on that same edge.
- Debounce, on each tick, per bit:
  - Shift the synchronised value into a STABLE_SAMPLES-deep history register.
  - If all history bits including the new sample are equal, load that value into the debounced register on the same edge. Otherwise hold.
  - Worst-case latency from a stable pin change: 2 + STABLE_SAMPLES*SAMPLE_PERIOD cycles.
- Edge capture:
  - prev_btn is a registered copy of debounced btn.
  - EDGE[i] sets on the cycle after debounced btn[i] rises (debounced btn[i] & ~prev_btn[i]).
  - Releases never set EDGE.
  - Set and W1C on the same bit in the same cycle: set wins, flag stays 1.
  - Flags remain set while the button is held. Clearing while held does not re-set until a new 0->1 transition.
- irq = |(EDGE & IE), combinational from registers. No glitch on reads.
- Reads have no side effects.
- Reset mid-debounce discards history. Inputs already stable at reset release appear after the full debounce latency.

Decomposition:
- Shared package: register word offsets (SW_LO, SW_HI, BTN, CTRL) and CTRL field positions (EDGE [7:0], IE [15:8]).
- One sub-module: input_debouncer, parameterised by width and STABLE_SAMPLES.
  - Contains the synchroniser, optional inversion and the history registers.
  - Takes tick as an input.
  - Instantiated twice: width 64 for switches, width 8 for buttons.
- The sample counter lives in the top module and is shared by both instances.

Test Plan (SAMPLE_PERIOD=4, STABLE_SAMPLES=3, ACTIVE_LOW=1):
- Reset, all pins high -> SW_LO, SW_HI and BTN read 0, CTRL reads 0, irq=0. Continues to read 0 after 20 cycles.
- sw[0]=0 and sw[63]=0 held stable -> within 14 cycles SW_LO=0x00000001 and SW_HI=0x80000000. Neither changes earlier than 2 + 2*4 cycles.
- btn[2] toggled every 3 cycles for 30 cycles, then held high -> BTN stays 0 and EDGE stays 0 throughout.
- Write CTRL 0x0400 (IE[2]), ByteEn=4'b0010; press btn[2] stably -> BTN=0x04, then 1 cycle later CTRL=0x0404 and irq=1.
- Write CTRL Din=0x04, ByteEn=4'b0001, btn[2] still held -> CTRL=0x0400, irq=0. Release and re-press btn[2] -> EDGE[2]=1 again.
- Force W1C of EDGE[3] in the same cycle that btn[3]'s rising edge sets it -> EDGE[3]=1. Write with ByteEn=0 to CTRL -> no register change. Read 0x7f70 -> 0.
